serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  operands i_a, i_b, i_cin are valid this cycle.
REQ-005 SHALL have port o_ready  output  1  block can accept operands this cycle.
REQ-006 SHALL have port i_a  input  WIDTH  operand A.
REQ-007 SHALL have port i_b  input  WIDTH  operand B.
REQ-008 SHALL have port i_cin  input  1  carry-in for bit 0.
REQ-009 SHALL have port o_sum  output  WIDTH  result sum bits.
REQ-010 SHALL have port o_carry  output  1  carry-out of bit WIDTH-1.
REQ-011 SHALL have port o_valid  output  1  o_sum/o_carry hold a completed result.
REQ-012 SHALL have port i_ready  input  1  consumer accepts the result this cycle.
REQ-013 SHALL have port o_busy  output  1  addition in progress (ADD state).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-015 SHALL assert o_ready only in IDLE (Moore output, no combinational path from i_valid).
REQ-016 SHALL accept operands on a rising edge where state=IDLE and i_valid=1: latch i_a, i_b into shift registers, load carry register with i_cin, clear bit counter and o_sum, go to ADD.
REQ-017 SHALL, in ADD, process one bit per clock LSB-first: sum bit = a0 XOR b0 XOR carry, next carry = majority(a0, b0, carry), formed from two half adders plus OR.
REQ-018 SHALL shift each sum bit into o_sum from the MSB end so that after WIDTH ADD cycles o_sum[k] holds bit k of the sum.
REQ-019 SHALL transition ADD->DONE on the edge that processes bit WIDTH-1; o_valid SHALL first be high exactly WIDTH rising edges after the accept edge.
REQ-020 SHALL set o_carry to the final carry register value on entry to DONE; o_sum and o_carry SHALL equal (i_a + i_b + i_cin) split as {o_carry, o_sum}.
REQ-021 SHALL hold o_valid, o_sum, o_carry stable in DONE until an edge with i_ready=1, then go to IDLE (o_valid low next cycle).
REQ-022 SHALL ignore i_valid in ADD and DONE; operands SHALL not be re-sampled mid-operation.
REQ-023 SHALL ignore i_ready outside DONE.
REQ-024 SHALL, with i_ready tied high, sustain one result every WIDTH+2 cycles (accept, WIDTH ADD edges, DONE, IDLE).
REQ-025 SHALL handle WIDTH=1: a single ADD edge, then DONE.
REQ-026 SHALL keep o_sum and o_carry at their last DONE values in IDLE until the next accept clears them.
REQ-027 SHALL assert o_busy only in ADD.

Reset
REQ-028 SHALL, on i_rst high, immediately (asynchronously) force state IDLE, o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0, bit counter and carry register 0.
REQ-029 SHALL abort any addition in progress on reset; no partial result SHALL ever be presented with o_valid=1.
REQ-030 SHALL resume normal operation on the first rising edge after i_rst deasserts.

Structure
REQ-031 SHALL place state encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and default WIDTH in shared package serial_adder_pkg.
REQ-032 SHALL instantiate the existing half_adder module twice for the per-bit full-add; no other sub-module.
REQ-033 SHALL size the bit counter as clog2(WIDTH+1) bits.

Verification
REQ-034 WIDTH=8, i_a=8'h03, i_b=8'h05, i_cin=0, i_ready=1 -> o_valid exactly 8 edges after accept, o_sum=8'h08, o_carry=0.
REQ-035 i_a=8'hFF, i_b=8'h01, i_cin=1 -> o_sum=8'h01, o_carry=1.
REQ-036 i_ready held 0 for 5 cycles after o_valid -> o_valid, o_sum stable all 5 cycles; IDLE one cycle after i_ready=1 edge.
REQ-037 i_valid pulsed with i_a=8'hAA during ADD -> ignored, result of original operands unchanged, o_ready stays 0.
REQ-038 i_rst asserted at bit 4 of 8'h7F+8'h7F -> o_valid=0, o_sum=0, o_ready=1 immediately; next op 8'h10+8'h20 gives 8'h30.
REQ-039 Back-to-back random operands, i_ready=1, 1000 ops -> every result matches reference sum, period WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR form the per-bit full add of serial_adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule : half_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in, adds one bit per clock
// LSB-first, and presents {o_carry, o_sum} with a valid/ready handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_shift;
    logic [CNT_W-1:0] bit_cnt;
    logic             carry_q;
    logic             ha0_sum;
    logic             ha0_carry;
    logic             sum_bit;
    logic             ha1_carry;
    logic             carry_next;

    half_adder u_ha0 (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    half_adder u_ha1 (
        .a     (ha0_sum),
        .b     (carry_q),
        .sum   (sum_bit),
        .carry (ha1_carry)
    );

    assign carry_next = ha0_carry | ha1_carry;

    // New sum bit enters at the MSB so that after WIDTH shifts bit k sits at o_sum[k].
    always_comb begin
        // NOTE: assign a full default first so no path through this block infers a latch.
        sum_shift            = o_sum >> 1;
        sum_shift[WIDTH-1]   = sum_bit;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            bit_cnt <= '0;
            carry_q <= 1'b0;
            o_sum   <= '0;
            o_carry <= 1'b0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sr    <= i_a;
                        b_sr    <= i_b;
                        carry_q <= i_cin;
                        bit_cnt <= '0;
                        o_sum   <= '0;
                        o_carry <= 1'b0;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= ADD;
                    end
                end

                ADD: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= carry_next;
                    o_sum   <= sum_shift;
                    bit_cnt <= bit_cnt + CNT_ONE;
                    if (bit_cnt == LAST_BIT) begin
                        o_carry <= carry_next;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder
